// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent down-counting timers behind one chip-selected
// 32-bit bus slot. Each channel has a prescaler, one-shot/periodic mode,
// an interrupt enable and a write-1-to-clear pending flag.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   cs, write         bus select / direction (1 = write, 0 = read)
//   address           {channel, reg[1:0]}; reg 0 RELOAD, 1 CONTROL, 2 CURRENT, 3 PRESCALE
//   data_in           write data (truncated to WIDTH for counter registers)
//   data_out          registered read data, valid one clock after the read edge
//   irq_vec           per-channel PENDING & IRQ_EN
//   irq               OR of irq_vec

// Per-channel timer state and register file.
module multi_timer_chan #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        pending,
    output logic        irq_en
);
    logic [WIDTH-1:0] reload_q, reload_d, prescale_q, prescale_d;
    logic [WIDTH-1:0] current_q, current_d, pcnt_q, pcnt_d;
    logic periodic_q, periodic_d, irq_en_q, irq_en_d;
    logic pending_q, pending_d, running_q, running_d;
    logic ctrl_wr, start, stop, step, tick, expire;

    always_comb begin
        reload_d   = reload_q;
        prescale_d = prescale_q;
        current_d  = current_q;
        pcnt_d     = pcnt_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        pending_d  = pending_q;
        running_d  = running_q;
        tick       = 1'b0;
        expire     = 1'b0;

        ctrl_wr = wr_en && (reg_sel == 2'd1);
        start   = ctrl_wr && wdata[0];
        stop    = ctrl_wr && wdata[1];
        // A START or STOP edge replaces the count step: STOP freezes the
        // counters at their current values, START reloads them.
        step    = running_q && !start && !stop;

        if (step) begin
            if (pcnt_q == '0) begin
                pcnt_d = prescale_q;
                tick   = 1'b1;
            end else begin
                pcnt_d = pcnt_q - WIDTH'(1);
            end
            if (tick) begin
                if (current_q == '0) begin
                    expire    = 1'b1;
                    pending_d = 1'b1;
                    current_d = reload_q;
                    if (!periodic_q) running_d = 1'b0;
                end else begin
                    current_d = current_q - WIDTH'(1);
                end
            end
        end

        if (wr_en) begin
            case (reg_sel)
                2'd0: reload_d = wdata[WIDTH-1:0];
                2'd1: begin
                    periodic_d = wdata[2];
                    irq_en_d   = wdata[3];
                    // An expiry on the same edge beats the clear.
                    if (wdata[4] && !expire) pending_d = 1'b0;
                end
                2'd3: prescale_d = wdata[WIDTH-1:0];
                default: ;  // CURRENT is read-only
            endcase
        end

        if (start) begin
            running_d = 1'b1;
            current_d = reload_q;
            pcnt_d    = prescale_q;
        end else if (stop) begin
            running_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reload_q   <= '0;
            prescale_q <= '0;
            current_q  <= '0;
            pcnt_q     <= '0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            current_q  <= current_d;
            pcnt_q     <= pcnt_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            running_q  <= running_d;
        end
    end

    always_comb begin
        case (reg_sel)
            2'd0:    rdata = 32'(reload_q);
            2'd1:    rdata = {26'd0, running_q, pending_q, irq_en_q, periodic_q, 2'b00};
            2'd2:    rdata = 32'(current_q);
            default: rdata = 32'(prescale_q);
        endcase
    end

    assign pending = pending_q;
    assign irq_en  = irq_en_q;
endmodule

module multi_timer #(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 32,
    localparam int ADDR_W   = $clog2(CHANNELS) + 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cs,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic [CHANNELS-1:0] irq_vec,
    output logic                irq
);
    logic [ADDR_W-1:0]               chan_idx;
    logic [CHANNELS-1:0]             chan_wr, pending, irq_en;
    logic [CHANNELS-1:0][31:0]       rdata_all;
    logic [31:0]                     rd_sel, data_out_q, data_out_d;

    assign chan_idx = address >> 2;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign chan_wr[i] = cs && write && (chan_idx == ADDR_W'(i));
        multi_timer_chan #(.WIDTH(WIDTH)) u_chan (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (chan_wr[i]),
            .reg_sel (address[1:0]),
            .wdata   (data_in),
            .rdata   (rdata_all[i]),
            .pending (pending[i]),
            .irq_en  (irq_en[i])
        );
    end

    // Channel indices at or above CHANNELS match nothing and read 0.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (chan_idx == ADDR_W'(i)) rd_sel = rdata_all[i];
        data_out_d = (cs && !write) ? rd_sel : data_out_q;
    end

    always_ff @(posedge clock) begin
        if (reset) data_out_q <= '0;
        else       data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
    assign irq_vec  = pending & irq_en;
    assign irq      = |irq_vec;
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer with CHANNELS=3, WIDTH=16 so that both
// truncation and an out-of-range channel index (3) can be exercised.
// Every bus task spans exactly one rising edge: it drives at a falling edge
// and returns at the next falling edge, where outputs are sampled.
module tb_multi_timer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0, write = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [2:0]  irq_vec;
    logic        irq;
    int passed = 0, total = 0;

    multi_timer #(.CHANNELS(3), .WIDTH(16)) dut (
        .clock(clock), .reset(reset), .cs(cs), .write(write), .address(address),
        .data_in(data_in), .data_out(data_out), .irq_vec(irq_vec), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; address = 4'((ch << 2) | r); data_in = d;
        @(negedge clock);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        cs = 1'b1; write = 1'b0; address = 4'((ch << 2) | r);
        @(negedge clock);
        cs = 1'b0;
        v = data_out;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        total++; if (data_out !== 32'h0) $display("FAIL reset_data_out got=%h exp=0", data_out); else passed++;
        total++; if (irq !== 1'b0 || irq_vec !== 3'b000) $display("FAIL reset_irq got=%b/%b exp=0/000", irq, irq_vec); else passed++;
        for (int r = 0; r < 4; r++) begin
            rd(0, r, v);
            total++; if (v !== 32'h0) $display("FAIL reset_ch0_reg%0d got=%h exp=0", r, v); else passed++;
            rd(2, r, v);
            total++; if (v !== 32'h0) $display("FAIL reset_ch2_reg%0d got=%h exp=0", r, v); else passed++;
        end
    endtask

    // RELOAD=3, PRESCALE=0: expiry 4 edges after START.
    task automatic test_oneshot;
        logic [31:0] v;
        wr(0, 0, 3); wr(0, 3, 0); wr(0, 1, 32'h08);
        wr(0, 1, 32'h09);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            total++;
            if (irq !== (k == 4)) $display("FAIL oneshot_irq_k%0d got=%b exp=%b", k, irq, (k == 4)); else passed++;
        end
        total++; if (irq_vec !== 3'b001) $display("FAIL oneshot_vec got=%b exp=001", irq_vec); else passed++;
        rd(0, 1, v);
        total++; if (v !== 32'h18) $display("FAIL oneshot_ctrl got=%h exp=18", v); else passed++;
        rd(0, 2, v);
        total++; if (v !== 32'h3) $display("FAIL oneshot_current got=%h exp=3", v); else passed++;
        wr(0, 1, 32'h18);
        total++; if (irq !== 1'b0) $display("FAIL oneshot_clear got=%b exp=0", irq); else passed++;
    endtask

    // RELOAD=2, PRESCALE=1 periodic: period 6.
    task automatic test_periodic;
        logic [31:0] v;
        wr(1, 0, 2); wr(1, 3, 1);
        wr(1, 1, 32'h0D);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            total++;
            if (irq !== (k == 6)) $display("FAIL periodic_first_k%0d got=%b exp=%b", k, irq, (k == 6)); else passed++;
        end
        wr(1, 1, 32'h1C);
        total++; if (irq !== 1'b0 || irq_vec !== 3'b000) $display("FAIL periodic_clear got=%b/%b exp=0/000", irq, irq_vec); else passed++;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            total++;
            if (irq !== (k == 5)) $display("FAIL periodic_second_k%0d got=%b exp=%b", k, irq, (k == 5)); else passed++;
        end
        rd(1, 1, v);
        total++; if (v !== 32'h3C) $display("FAIL periodic_ctrl got=%h exp=3c", v); else passed++;
        wr(1, 1, 32'h12);
    endtask

    // RELOAD=10: restart when CURRENT holds 4.
    task automatic test_restart;
        logic [31:0] v;
        wr(0, 0, 10);
        wr(0, 1, 32'h09);
        idle(6);
        wr(0, 1, 32'h09);
        rd(0, 2, v);
        total++; if (v !== 32'd10) $display("FAIL restart_current got=%0d exp=10", v); else passed++;
        rd(0, 1, v);
        total++; if (v !== 32'h28) $display("FAIL restart_ctrl got=%h exp=28", v); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL restart_irq got=%b exp=0", irq); else passed++;
    endtask

    task automatic test_stop;
        logic [31:0] v;
        wr(0, 1, 32'h09);
        idle(5);
        wr(0, 1, 32'h0A);
        idle(20);
        rd(0, 2, v);
        total++; if (v !== 32'd5) $display("FAIL stop_hold got=%0d exp=5", v); else passed++;
        rd(0, 1, v);
        total++; if (v !== 32'h08) $display("FAIL stop_ctrl got=%h exp=08", v); else passed++;
        wr(0, 1, 32'h03);
        rd(0, 2, v);
        total++; if (v !== 32'd10) $display("FAIL start_wins_current got=%0d exp=10", v); else passed++;
        rd(0, 1, v);
        total++; if (v !== 32'h20) $display("FAIL start_wins_ctrl got=%h exp=20", v); else passed++;
        wr(0, 1, 32'h02);
    endtask

    // Channel 1 starts with PRESCALE=4 and is retuned to 2 while running so
    // that, once channel 2 starts two edges later, both hold pcnt=2, CURRENT=1.
    task automatic test_simultaneous;
        wr(1, 0, 1); wr(1, 3, 4); wr(2, 0, 1); wr(2, 3, 2);
        wr(1, 1, 32'h09);
        wr(1, 3, 2);
        wr(2, 1, 32'h09);
        idle(5);
        total++; if (irq_vec !== 3'b000) $display("FAIL simul_before got=%b exp=000", irq_vec); else passed++;
        idle(1);
        total++; if (irq_vec !== 3'b110 || irq !== 1'b1) $display("FAIL simul_both got=%b/%b exp=110/1", irq_vec, irq); else passed++;
        wr(1, 1, 32'h18);
        total++; if (irq_vec !== 3'b100 || irq !== 1'b1) $display("FAIL simul_one_left got=%b/%b exp=100/1", irq_vec, irq); else passed++;
        wr(2, 1, 32'h18);
        total++; if (irq !== 1'b0) $display("FAIL simul_all_clear got=%b exp=0", irq); else passed++;
    endtask

    // RELOAD=0, PRESCALE=0 periodic: expires every edge, clear loses.
    task automatic test_every_clock;
        wr(2, 0, 0); wr(2, 3, 0);
        wr(2, 1, 32'h0D);
        idle(1);
        total++; if (irq_vec !== 3'b100) $display("FAIL every_first got=%b exp=100", irq_vec); else passed++;
        wr(2, 1, 32'h1C);
        total++; if (irq_vec !== 3'b100) $display("FAIL every_set_wins got=%b exp=100", irq_vec); else passed++;
        wr(2, 1, 32'h0A);
        wr(2, 1, 32'h18);
        total++; if (irq !== 1'b0) $display("FAIL every_stopped_clear got=%b exp=0", irq); else passed++;
    endtask

    task automatic test_width;
        logic [31:0] v;
        wr(0, 0, 32'h0001_2345);
        rd(0, 0, v);
        total++; if (v !== 32'h2345) $display("FAIL trunc_reload got=%h exp=2345", v); else passed++;
        wr(0, 3, 32'hFFFF_ABCD);
        rd(0, 3, v);
        total++; if (v !== 32'hABCD) $display("FAIL trunc_prescale got=%h exp=abcd", v); else passed++;
        wr(0, 2, 32'h77);
        rd(0, 2, v);
        total++; if (v !== 32'd8) $display("FAIL current_ro got=%h exp=8", v); else passed++;
        wr(3, 0, 5);
        rd(3, 0, v);
        total++; if (v !== 32'h0) $display("FAIL oob_reload got=%h exp=0", v); else passed++;
        rd(3, 1, v);
        total++; if (v !== 32'h0) $display("FAIL oob_ctrl got=%h exp=0", v); else passed++;
    endtask

    task automatic test_reset_mid_count;
        logic [31:0] v;
        wr(1, 0, 5);
        wr(1, 1, 32'h09);
        rd(1, 1, v);
        idle(1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++; if (data_out !== 32'h0) $display("FAIL mid_reset_data_out got=%h exp=0", data_out); else passed++;
        for (int r = 0; r < 4; r++) begin
            rd(1, r, v);
            total++; if (v !== 32'h0) $display("FAIL mid_reset_ch1_reg%0d got=%h exp=0", r, v); else passed++;
        end
        total++; if (irq !== 1'b0) $display("FAIL mid_reset_irq got=%b exp=0", irq); else passed++;
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_restart();
        test_stop();
        test_simultaneous();
        test_every_clock();
        test_width();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
